// File: rtl/t5_barb.sv
// rtl/t5_barb.sv - single-port Wishbone arbiter/sequencer for fetch and data masters
module t5_barb #(
  parameter logic [7:0] TOUT = 8'd255
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic [29:0] iwb_adr,
  input  logic        iwb_stb,
  input  logic [3:0]  iwb_sel,
  output logic [31:0] iwb_dat,
  output logic        iwb_ack,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_wdat,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  input  logic [3:0]  dwb_sel,
  output logic [31:0] dwb_dat,
  output logic        dwb_ack,
  output logic [29:0] xwb_adr,
  output logic [31:0] xwb_wdat,
  output logic        xwb_stb,
  output logic        xwb_wre,
  output logic [3:0]  xwb_sel,
  input  logic [31:0] xwb_rdat,
  input  logic        xwb_ack,
  output logic        sena,
  output logic        serr
);

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

  state_t      state_q, state_d;
  logic        idone_q, idone_d;
  logic        ddone_q, ddone_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        serr_q, serr_d;
  logic [31:0] iwb_dat_q, iwb_dat_d;
  logic [31:0] dwb_dat_q, dwb_dat_d;

  logic        grant;
  logic        tout_hit;
  logic        done_now;
  logic [31:0] rdat_eff;

  // Next-state, bus steering, completion handling and pipeline enable
  always_comb begin
    state_d   = state_q;
    idone_d   = idone_q;
    ddone_d   = ddone_q;
    cnt_d     = cnt_q;
    serr_d    = serr_q;
    iwb_dat_d = iwb_dat_q;
    dwb_dat_d = dwb_dat_q;
    xwb_stb   = 1'b0;
    xwb_wre   = 1'b0;
    xwb_adr   = 30'h0;
    xwb_wdat  = 32'h0;
    xwb_sel   = 4'h0;

    grant    = (state_q != IDLE);
    // A transfer that times out completes like an ack carrying zero data
    tout_hit = grant && !xwb_ack && (cnt_q == TOUT - 8'd1);
    done_now = grant && (xwb_ack || tout_hit);
    rdat_eff = xwb_ack ? xwb_rdat : 32'h0;

    sena = (state_q == IDLE) && (!iwb_stb || idone_q) && (!dwb_stb || ddone_q);

    // Acks are suppressed under reset so an aborted transfer never completes
    iwb_ack = (state_q == IGNT) && done_now && !srst;
    dwb_ack = (state_q == DGNT) && done_now && !srst;

    case (state_q)
      IDLE: begin
        cnt_d = 8'h0;
        if (dwb_stb && !ddone_q) begin
          state_d = DGNT;
        end else if (iwb_stb && !idone_q) begin
          state_d = IGNT;
        end
        if (sena) begin
          idone_d = 1'b0;
          ddone_d = 1'b0;
        end
      end
      DGNT: begin
        xwb_stb  = 1'b1;
        xwb_wre  = dwb_wre;
        xwb_adr  = dwb_adr;
        xwb_wdat = dwb_wdat;
        xwb_sel  = dwb_sel;
        if (done_now) begin
          dwb_dat_d = rdat_eff;
          ddone_d   = 1'b1;
          cnt_d     = 8'h0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IGNT: begin
        xwb_stb = 1'b1;
        xwb_adr = iwb_adr;
        xwb_sel = iwb_sel;
        if (done_now) begin
          iwb_dat_d = rdat_eff;
          idone_d   = 1'b1;
          cnt_d     = 8'h0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tout_hit) begin
      serr_d = 1'b1;
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q   <= IDLE;
      idone_q   <= 1'b0;
      ddone_q   <= 1'b0;
      cnt_q     <= 8'h0;
      serr_q    <= 1'b0;
      iwb_dat_q <= 32'h0;
      dwb_dat_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      idone_q   <= idone_d;
      ddone_q   <= ddone_d;
      cnt_q     <= cnt_d;
      serr_q    <= serr_d;
      iwb_dat_q <= iwb_dat_d;
      dwb_dat_q <= dwb_dat_d;
    end
  end

  assign iwb_dat = iwb_dat_q;
  assign dwb_dat = dwb_dat_q;
  assign serr    = serr_q;

endmodule

// File: tb/tb_t5_barb.sv
// tb/tb_t5_barb.sv - cycle-vector bench for t5_barb
module tb_t5_barb;

  logic        sclk = 1'b0;
  logic        srst;
  logic [29:0] iwb_adr;
  logic        iwb_stb;
  logic [3:0]  iwb_sel;
  logic [31:0] iwb_dat;
  logic        iwb_ack;
  logic [29:0] dwb_adr;
  logic [31:0] dwb_wdat;
  logic        dwb_stb;
  logic        dwb_wre;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dat;
  logic        dwb_ack;
  logic [29:0] xwb_adr;
  logic [31:0] xwb_wdat;
  logic        xwb_stb;
  logic        xwb_wre;
  logic [3:0]  xwb_sel;
  logic [31:0] xwb_rdat;
  logic        xwb_ack;
  logic        sena;
  logic        serr;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [29:0] A_I = 30'h31;
  localparam logic [29:0] A_D = 30'h10;
  localparam logic [31:0] WD  = 32'h12345678;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] AA  = 32'hAAAA5555;
  localparam logic [31:0] CF  = 32'hCAFEF00D;
  localparam logic [31:0] BD  = 32'h0BADC0DE;

  always #5 sclk = ~sclk;

  t5_barb #(.TOUT(8'd4)) dut (
    .sclk(sclk), .srst(srst),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_sel(iwb_sel), .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dwb_adr(dwb_adr), .dwb_wdat(dwb_wdat), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel),
    .dwb_dat(dwb_dat), .dwb_ack(dwb_ack),
    .xwb_adr(xwb_adr), .xwb_wdat(xwb_wdat), .xwb_stb(xwb_stb), .xwb_wre(xwb_wre), .xwb_sel(xwb_sel),
    .xwb_rdat(xwb_rdat), .xwb_ack(xwb_ack), .sena(sena), .serr(serr)
  );

  typedef struct {
    logic        rst, istb, dstb, dwre, xack;
    logic [31:0] rdat;
    logic        e_xstb, e_xwre;
    logic [29:0] e_xadr;
    logic [31:0] e_xwdat;
    logic        e_iack, e_dack, e_sena, e_serr;
    logic [31:0] e_idat, e_ddat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, istb, dstb, dwre, xack, input logic [31:0] rdat,
                     input logic xs, xw, input logic [29:0] xa, input logic [31:0] xd,
                     input logic ia, da, se, sr, input logic [31:0] id, dd);
    vec_t v;
    v = '{rst, istb, dstb, dwre, xack, rdat, xs, xw, xa, xd, ia, da, se, sr, id, dd};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Cycles from strobe assertion until sena rises, with acks always present
  task automatic lat(input logic i, input logic d, input int exp_n, input string nm);
    int n;
    n = 0;
    iwb_stb = i; dwb_stb = d; dwb_wre = 1'b0; xwb_ack = 1'b1; xwb_rdat = 32'h5A5A5A5A;
    #1;
    while (!sena && n < 20) begin
      @(posedge sclk); #1;
      n++;
    end
    check(nm, -1, n, exp_n);
    iwb_stb = 1'b0; dwb_stb = 1'b0; xwb_ack = 1'b0;
    @(posedge sclk); #1;
  endtask

  initial begin
    srst = 1'b1; iwb_adr = A_I; iwb_stb = 1'b0; iwb_sel = 4'hF;
    dwb_adr = A_D; dwb_wdat = WD; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = 4'hF;
    xwb_rdat = 32'h0; xwb_ack = 1'b0;

    //   rst i d w x rdat           | xs xw xadr  xwdat ia da se sr idat ddat
    add(1, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,1, DB,             1, 0, A_I,   32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, DB,    32'h0);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, DB,    32'h0);
    add(0, 1,1,1,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, DB,    32'h0);
    add(0, 1,1,1,1, AA,             1, 1, A_D,   WD,    0, 1, 0, 0, DB,    32'h0);
    add(0, 1,1,1,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, DB,    AA);
    add(0, 1,1,1,1, CF,             1, 0, A_I,   32'h0, 1, 0, 0, 0, DB,    AA);
    add(0, 1,1,1,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, CF,    AA);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, CF,    AA);
    add(0, 0,1,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, CF,    AA);
    add(0, 0,1,0,0, 32'h0,          1, 0, A_D,   WD,    0, 0, 0, 0, CF,    AA);
    add(0, 0,1,0,0, 32'h0,          1, 0, A_D,   WD,    0, 0, 0, 0, CF,    AA);
    add(0, 0,1,0,0, 32'h0,          1, 0, A_D,   WD,    0, 0, 0, 0, CF,    AA);
    add(0, 0,1,0,1, BD,             1, 0, A_D,   WD,    0, 1, 0, 0, CF,    AA);
    add(0, 0,1,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, CF,    BD);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, CF,    BD);
    add(0, 0,1,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, CF,    BD);
    add(0, 0,1,0,0, 32'h0,          1, 0, A_D,   WD,    0, 0, 0, 0, CF,    BD);
    add(1, 0,1,0,1, 32'hFFFFFFFF,   1, 0, A_D,   WD,    0, 0, 0, 0, CF,    BD);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'hFFFFFFFF,   1, 0, A_I,   32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'hFFFFFFFF,   1, 0, A_I,   32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'hFFFFFFFF,   1, 0, A_I,   32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'hFFFFFFFF,   1, 0, A_I,   32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    add(0, 1,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h0);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h0);
    add(0, 0,0,0,1, 32'h12345678,   0, 0, 30'h0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h0);
    add(1, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h0);
    add(0, 0,0,0,0, 32'h0,          0, 0, 30'h0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);

    repeat (2) @(posedge sclk);
    #1;

    foreach (vecs[r]) begin
      srst = vecs[r].rst; iwb_stb = vecs[r].istb; dwb_stb = vecs[r].dstb;
      dwb_wre = vecs[r].dwre; xwb_ack = vecs[r].xack; xwb_rdat = vecs[r].rdat;
      #1;
      check("xwb_stb",  r, 32'(xwb_stb),  32'(vecs[r].e_xstb));
      check("xwb_wre",  r, 32'(xwb_wre),  32'(vecs[r].e_xwre));
      check("xwb_adr",  r, 32'(xwb_adr),  32'(vecs[r].e_xadr));
      check("xwb_wdat", r, xwb_wdat,      vecs[r].e_xwdat);
      check("iwb_ack",  r, 32'(iwb_ack),  32'(vecs[r].e_iack));
      check("dwb_ack",  r, 32'(dwb_ack),  32'(vecs[r].e_dack));
      check("sena",     r, 32'(sena),     32'(vecs[r].e_sena));
      check("serr",     r, 32'(serr),     32'(vecs[r].e_serr));
      check("iwb_dat",  r, iwb_dat,       vecs[r].e_idat);
      check("dwb_dat",  r, dwb_dat,       vecs[r].e_ddat);
      @(posedge sclk); #1;
    end

    srst = 1'b0;
    lat(1'b1, 1'b0, 2, "lat_fetch_only");
    lat(1'b1, 1'b1, 4, "lat_fetch_and_data");
    lat(1'b0, 1'b1, 2, "lat_data_only");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
